// File: rtl/scan_accum_pkg.sv
// rtl/scan_accum_pkg.sv - shared types and the fold operator for the scan/accumulate engine
//
// Contents:
//   FOLD_W  : datapath width of fold(); engine widths up to FOLD_W are supported
//   op_e    : fold operator select (add / signed max / signed min / xor)
//   state_e : engine FSM states
//   fold()  : acc' = f(acc, elem) on FOLD_W-bit two's complement operands
package scan_accum_pkg;

   localparam int FOLD_W = 64;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_MAX = 2'd1,
      OP_MIN = 2'd2,
      OP_XOR = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Callers sign-extend narrower operands to FOLD_W and keep the low bits of
   // the result; that makes add wrap at the caller's width and keeps the
   // signed compares correct. Ties in max/min keep the accumulator.
   function automatic logic [FOLD_W-1:0] fold(input op_e op,
                                              input logic [FOLD_W-1:0] acc,
                                              input logic [FOLD_W-1:0] elem);
      logic [FOLD_W-1:0] r;
      case (op)
         OP_ADD:  r = acc + elem;
         OP_MAX:  r = ($signed(elem) > $signed(acc)) ? elem : acc;
         OP_MIN:  r = ($signed(elem) < $signed(acc)) ? elem : acc;
         default: r = acc ^ elem;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/scan_mem.sv
// rtl/scan_mem.sv - simple dual-port element array, registered-address read port
//
// Ports:
//   clk        in  clock
//   rd_addr_i  in  read address, registered; data appears the following cycle
//   rd_data_o  out read data (0 when the registered address is >= DEPTH)
//   wr_en_i    in  write enable (writes to addresses >= DEPTH are dropped)
//   wr_addr_i  in  write address
//   wr_data_i  in  write data
module scan_mem #(
   parameter int W     = 64,
   parameter int DEPTH = 1000,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i
);

   localparam logic [AW:0] DEPTH_E = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_addr_q;

   // The array itself is never reset; contents survive an engine reset.
   always_ff @(posedge clk) begin
      rd_addr_q <= rd_addr_i;
      if (wr_en_i && ({1'b0, wr_addr_i} < DEPTH_E)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = ({1'b0, rd_addr_q} < DEPTH_E) ? mem_q[rd_addr_q] : '0;

endmodule

// File: rtl/scan_accum_engine.sv
// rtl/scan_accum_engine.sv - streaming reduce / inclusive prefix scan over an on-block array
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  one-cycle run request, honoured only in IDLE
//   start_idx, end_idx     element range [start_idx, end_idx); end clamped to DEPTH
//   init_acc, op, scan     accumulator seed, fold operator, write-back enable
//   busy, done, result     run status, one-cycle completion pulse, final accumulator
//   host_en, host_we       host array access (IDLE only), write qualifier
//   host_addr, host_wdata  host address / write data
//   host_rdata             host read data, one cycle after the request, 0 when not serviced
module scan_accum_engine
   import scan_accum_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 1000,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_idx,
   input  logic [AW:0]   end_idx,
   input  logic [W-1:0]  init_acc,
   input  logic [1:0]    op,
   input  logic          scan,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result,
   input  logic          host_en,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [W-1:0]  host_wdata,
   output logic [W-1:0]  host_rdata
);

   localparam logic [AW:0] DEPTH_E = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [AW-1:0] i_q, i_d;          // next element to read
   logic [AW-1:0] j_q, j_d;          // element whose data is returning this cycle
   logic [AW:0]   e_q, e_d;          // clamped exclusive end
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  result_q, result_d;
   op_e           op_q, op_d;
   logic          scan_q, scan_d;
   logic          rd_valid_q, rd_valid_d;   // a[j_q] is on the memory read port
   logic          host_rd_q, host_rd_d;     // host_rdata carries a serviced read

   logic              is_idle;
   logic              host_in_range;
   logic              host_wr;
   logic [AW:0]       end_eff;
   logic [AW:0]       i_next;
   logic [W-1:0]      mem_rdata;
   logic [FOLD_W-1:0] fold_full;
   logic [W-1:0]      acc_nxt;

   logic [AW-1:0]     mem_rd_addr;
   logic              mem_wr_en;
   logic [AW-1:0]     mem_wr_addr;
   logic [W-1:0]      mem_wr_data;

   assign is_idle       = (state_q == IDLE);
   assign host_in_range = ({1'b0, host_addr} < DEPTH_E);
   assign host_wr       = is_idle && host_en && host_we && host_in_range;
   assign end_eff       = (end_idx > DEPTH_E) ? DEPTH_E : end_idx;
   assign i_next        = {1'b0, i_q} + (AW+1)'(1);

   // Operands are sign-extended so max/min compare as signed at width W.
   assign fold_full = fold(op_q, FOLD_W'($signed(acc_q)), FOLD_W'($signed(mem_rdata)));
   assign acc_nxt   = rd_valid_q ? fold_full[W-1:0] : acc_q;

   // The host owns both memory ports in IDLE, the engine owns them otherwise.
   // During a run the write-back address j trails the read address i by one,
   // so the two ports never touch the same element in the same cycle.
   assign mem_rd_addr = is_idle ? host_addr  : i_q;
   assign mem_wr_en   = is_idle ? host_wr    : (rd_valid_q && scan_q);
   assign mem_wr_addr = is_idle ? host_addr  : j_q;
   assign mem_wr_data = is_idle ? host_wdata : acc_nxt;

   scan_mem #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .rd_addr_i (mem_rd_addr),
      .rd_data_o (mem_rdata),
      .wr_en_i   (mem_wr_en),
      .wr_addr_i (mem_wr_addr),
      .wr_data_i (mem_wr_data)
   );

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      e_d        = e_q;
      acc_d      = acc_q;
      result_d   = result_q;
      op_d       = op_q;
      scan_d     = scan_q;
      rd_valid_d = 1'b0;
      host_rd_d  = is_idle && host_en && host_in_range;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op_e'(op);
               scan_d  = scan;
               acc_d   = init_acc;
               i_d     = start_idx;
               e_d     = end_eff;
               // An empty (or inverted) range skips straight to the drain step.
               state_d = ({1'b0, start_idx} >= end_eff) ? DRAIN : RUN;
            end
         end
         RUN: begin
            rd_valid_d = 1'b1;
            j_d        = i_q;
            i_d        = i_next[AW-1:0];
            acc_d      = acc_nxt;
            if (i_next == e_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Fold the final datum (if any) and publish so result is valid with done.
            acc_d    = acc_nxt;
            result_d = acc_nxt;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         e_q        <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         op_q       <= OP_ADD;
         scan_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         host_rd_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         e_q        <= e_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         op_q       <= op_d;
         scan_q     <= scan_d;
         rd_valid_q <= rd_valid_d;
         host_rd_q  <= host_rd_d;
      end
   end

   assign busy       = !is_idle;
   assign done       = (state_q == DONE);
   assign result     = result_q;
   assign host_rdata = host_rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_scan_accum_engine.sv
// tb/tb_scan_accum_engine.sv - directed scoreboard bench for scan_accum_engine
module tb_scan_accum_engine;

   localparam int W     = 64;
   localparam int DEPTH = 1000;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [1:0] ADD = 2'd0;
   localparam logic [1:0] MAX = 2'd1;
   localparam logic [1:0] MIN = 2'd2;
   localparam logic [1:0] XOR = 2'd3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_idx;
   logic [AW:0]   end_idx;
   logic [W-1:0]  init_acc;
   logic [1:0]    op;
   logic          scan;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          host_en;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [W-1:0]  host_wdata;
   logic [W-1:0]  host_rdata;

   int tests  = 0;
   int failed = 0;

   logic [W-1:0] exp_res[$];
   int           exp_lat[$];

   scan_accum_engine #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_idx  (start_idx),
      .end_idx    (end_idx),
      .init_acc   (init_acc),
      .op         (op),
      .scan       (scan),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .host_en    (host_en),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int a, input logic [W-1:0] d);
      @(negedge clk);
      host_en    = 1'b1;
      host_we    = 1'b1;
      host_addr  = a[AW-1:0];
      host_wdata = d;
      @(negedge clk);
      host_en = 1'b0;
      host_we = 1'b0;
   endtask

   task automatic read_chk(input int a, input logic [W-1:0] exp);
      @(negedge clk);
      host_en   = 1'b1;
      host_we   = 1'b0;
      host_addr = a[AW-1:0];
      @(negedge clk);
      host_en = 1'b0;
      check($sformatf("readback_a%0d", a), host_rdata, exp);
   endtask

   // Drives one run; expected result and done latency go on the scoreboard at
   // start and are popped when done is observed. With disturb set, the run is
   // also hit with a second start, a host write and a host read while busy.
   task automatic run(input int s, input int e, input logic [W-1:0] init, input logic [1:0] op_v,
                      input logic sc, input logic [W-1:0] exp_r, input int n, input bit disturb);
      int           lat;
      bit           seen;
      logic [W-1:0] r_exp;
      int           l_exp;
      @(negedge clk);
      start     = 1'b1;
      start_idx = s[AW-1:0];
      end_idx   = e[AW:0];
      init_acc  = init;
      op        = op_v;
      scan      = sc;
      exp_res.push_back(exp_r);
      exp_lat.push_back(n + 2);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      check("busy_cycle1", busy, 1);
      seen = 1'b0;
      while (!seen && lat < 2000) begin
         if (done) begin
            seen = 1'b1;
            check("sb_pending", exp_res.size() != 0, 1);
            if (exp_res.size() != 0) begin
               r_exp = exp_res.pop_front();
               l_exp = exp_lat.pop_front();
               check("result", result, r_exp);
               check("latency", lat, l_exp);
               check("busy_at_done", busy, 1);
            end
         end else begin
            if (disturb) begin
               if (lat == 2) begin
                  start      = 1'b1;
                  start_idx  = '0;
                  end_idx    = 2;
                  init_acc   = 99;
                  host_en    = 1'b1;
                  host_we    = 1'b1;
                  host_addr  = 8;
                  host_wdata = 64'hDEAD;
               end else if (lat == 3) begin
                  start     = 1'b0;
                  host_we   = 1'b0;
                  host_addr = 3;
               end else if (lat == 4) begin
                  host_en = 1'b0;
                  check("busy_host_rdata", host_rdata, 0);
               end
            end
            @(negedge clk);
            lat++;
         end
      end
      check("done_seen", seen, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_pulse_1cyc", done, 0);
      if (disturb) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_extra_run", {busy, done}, 0);
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      start_idx  = '0;
      end_idx    = '0;
      init_acc   = '0;
      op         = ADD;
      scan       = 1'b0;
      host_en    = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_host_rdata", host_rdata, 0);
      rst_n = 1'b1;

      // Plain reduce over a[k]=k
      for (int k = 0; k < 10; k++) host_write(k, W'(k));
      run(0, 10, 5, ADD, 1'b0, 50, 10, 1'b0);
      for (int k = 0; k < 10; k++) read_chk(k, W'(k));

      // Inclusive prefix scan over [2,6)
      run(2, 6, 0, ADD, 1'b1, 14, 4, 1'b0);
      read_chk(0, 0);
      read_chk(1, 1);
      read_chk(2, 2);
      read_chk(3, 5);
      read_chk(4, 9);
      read_chk(5, 14);
      read_chk(6, 6);
      read_chk(9, 9);

      // Second start and host traffic while busy are ignored
      run(0, 10, 0, ADD, 1'b0, 61, 10, 1'b1);
      read_chk(8, 8);

      // Reset in the third RUN cycle aborts the run
      @(negedge clk);
      start     = 1'b1;
      start_idx = '0;
      end_idx   = 10;
      init_acc  = '0;
      op        = ADD;
      scan      = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      rst_n = 1'b1;
      run(0, 4, 0, ADD, 1'b0, 8, 4, 1'b0);

      // Signed max / min / xor
      host_write(0, -64'sd7);
      host_write(1, 64'sd3);
      host_write(2, -64'sd20);
      host_write(3, 64'sd3);
      run(0, 4, -64'sd100, MAX, 1'b0, 64'sd3, 4, 1'b0);
      run(0, 4, 64'sd100, MIN, 1'b0, -64'sd20, 4, 1'b0);
      run(0, 4, 0, XOR, 1'b0, 64'd21, 4, 1'b0);

      // Add wraps modulo 2^W
      host_write(0, 64'h7FFF_FFFF_FFFF_FFFF);
      host_write(1, 64'd1);
      run(0, 2, 0, ADD, 1'b0, 64'h8000_0000_0000_0000, 2, 1'b0);

      // Empty and inverted ranges return the seed
      run(5, 5, 64'h1234, ADD, 1'b0, 64'h1234, 0, 1'b0);
      run(7, 3, -64'sd1, MAX, 1'b0, -64'sd1, 0, 1'b0);

      // end_idx beyond DEPTH is clamped
      for (int k = 0; k < 5; k++) host_write(DEPTH - 5 + k, W'(k + 1));
      run(DEPTH - 5, DEPTH + 20, 0, ADD, 1'b0, 15, 5, 1'b0);

      check("sb_empty", exp_res.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
